// File: rtl/safe_wrapper_ext_seq.sv
// safe_wrapper_ext_seq: sequences one job into the safe wrapper controller.
// A request is accepted in IDLE and its configuration is registered. The
// configuration is held for SETUP_CYCLES cycles before start rises. The
// block then waits for the end-of-routine flag, an abort or a watchdog
// timeout, and reports a completion status over a valid/ready handshake.
// Optional feature: define SAFE_WRAPPER_EXT_SEQ_TIMEOUT_EN to build in the
// RUN-cycle watchdog. Without it, timeout_limit_i is ignored and status 01
// is never produced.
module safe_wrapper_ext_seq #(
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned TIMEOUT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // job request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_master_core_i,
  input  logic                 req_safe_mode_i,
  input  logic [1:0]           req_safe_configuration_i,
  input  logic                 req_critical_section_i,
  input  logic [31:0]          req_boot_addr_i,
  input  logic [TIMEOUT_W-1:0] timeout_limit_i,
  input  logic                 abort_i,
  // safe wrapper controller side
  output logic [2:0]           ext_master_core_o,
  output logic                 ext_safe_mode_o,
  output logic [1:0]           ext_safe_configuration_o,
  output logic                 ext_critical_section_o,
  output logic                 ext_start_o,
  output logic [31:0]          boot_addr_o,
  input  logic                 end_sw_routine_i,
  // completion
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [1:0]           done_status_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W        = 8;
  localparam int unsigned BLANK_W      = 2;
  localparam int unsigned BLANK_CYCLES = 2;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]  master_core;
    logic        safe_mode;
    logic [1:0]  safe_configuration;
    logic        critical_section;
    logic [31:0] boot_addr;
  } cfg_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   setup_cnt_q, setup_cnt_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [1:0]         status_q, status_d;
  cfg_t               cfg_q, cfg_d;
  logic               start_q, start_d;
  logic               done_valid_q, done_valid_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;

  logic               req_fire;
  logic               end_ok;
  logic               timeout_hit;

  assign req_fire = req_valid_i && req_ready_q;

  // End flag only counts once the blanking window after start has elapsed
  assign end_ok = end_sw_routine_i && (blank_q == BLANK_W'(BLANK_CYCLES));

`ifdef SAFE_WRAPPER_EXT_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  // wd_q holds the RUN cycles already completed, so the current one is wd_q+1
  assign timeout_hit = (timeout_limit_i != '0) &&
                       (wd_q >= (timeout_limit_i - TIMEOUT_W'(1)));

  // Watchdog counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // Cleared on RUN entry, saturating count while in RUN
  always_comb begin
    wd_d = wd_q;
    if (state_q == SETUP && setup_cnt_q == '0) begin
      wd_d = '0;
    end else if (state_q == RUN && !(&wd_q)) begin
      wd_d = wd_q + TIMEOUT_W'(1);
    end
  end
`else
  logic unused_timeout_limit;

  assign unused_timeout_limit = ^timeout_limit_i;
  assign timeout_hit          = 1'b0;
`endif

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      blank_q     <= '0;
      status_q    <= ST_OK;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      blank_q     <= blank_d;
      status_q    <= status_d;
    end
  end

  // Next-state, counter and completion-status logic
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    blank_d     = blank_q;
    status_d    = status_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d     = SETUP;
          setup_cnt_d = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (abort_i) begin
          state_d  = DONE;
          status_d = ST_ABORT;
        end else if (setup_cnt_q == '0) begin
          state_d = RUN;
          blank_d = '0;
        end else begin
          setup_cnt_d = setup_cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (blank_q != BLANK_W'(BLANK_CYCLES)) begin
          blank_d = blank_q + BLANK_W'(1);
        end
        if (abort_i) begin
          state_d  = DONE;
          status_d = ST_ABORT;
        end else if (end_ok) begin
          state_d  = DONE;
          status_d = ST_OK;
        end else if (timeout_hit) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end
      end
      DONE: begin
        if (done_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values, decoded from the upcoming state so outputs align with it
  always_comb begin
    cfg_d        = cfg_q;
    start_d      = 1'b0;
    done_valid_d = 1'b0;
    req_ready_d  = 1'b0;
    busy_d       = 1'b1;
    if (req_fire) begin
      cfg_d.master_core        = req_master_core_i;
      cfg_d.safe_mode          = req_safe_mode_i;
      cfg_d.safe_configuration = req_safe_configuration_i;
      cfg_d.critical_section   = req_critical_section_i;
      cfg_d.boot_addr          = req_boot_addr_i;
    end
    case (state_d)
      IDLE: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      RUN:     start_d      = 1'b1;
      DONE:    done_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; the configuration is only rewritten by an accepted request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q        <= '0;
      start_q      <= 1'b0;
      done_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      cfg_q        <= cfg_d;
      start_q      <= start_d;
      done_valid_q <= done_valid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready_o              = req_ready_q;
  assign ext_master_core_o        = cfg_q.master_core;
  assign ext_safe_mode_o          = cfg_q.safe_mode;
  assign ext_safe_configuration_o = cfg_q.safe_configuration;
  assign ext_critical_section_o   = cfg_q.critical_section;
  assign boot_addr_o              = cfg_q.boot_addr;
  assign ext_start_o              = start_q;
  assign done_valid_o             = done_valid_q;
  assign done_status_o            = status_q;
  assign busy_o                   = busy_q;

endmodule

// File: tb/tb_safe_wrapper_ext_seq.sv
// Scoreboard bench for safe_wrapper_ext_seq: the driver pushes the expected
// completion for each job, and a monitor pops and compares on each completion.
module tb_safe_wrapper_ext_seq;

  localparam int S   = 4;
  localparam int TW  = 16;
  localparam int DIS = -99;
  localparam int BIG = 1000000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready_o;
  logic [2:0]    req_mc = '0;
  logic          req_sm = 1'b0;
  logic [1:0]    req_sc = '0;
  logic          req_cs = 1'b0;
  logic [31:0]   req_boot = '0;
  logic [TW-1:0] timeout_limit = '0;
  logic          abort = 1'b0;
  logic [2:0]    ext_master_core_o;
  logic          ext_safe_mode_o;
  logic [1:0]    ext_safe_configuration_o;
  logic          ext_critical_section_o;
  logic          ext_start_o;
  logic [31:0]   boot_addr_o;
  logic          end_sw = 1'b0;
  logic          done_valid_o;
  logic          done_ready = 1'b0;
  logic [1:0]    done_status_o;
  logic          busy_o;

  safe_wrapper_ext_seq #(.SETUP_CYCLES(S), .TIMEOUT_W(TW)) dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .req_valid_i              (req_valid),
    .req_ready_o              (req_ready_o),
    .req_master_core_i        (req_mc),
    .req_safe_mode_i          (req_sm),
    .req_safe_configuration_i (req_sc),
    .req_critical_section_i   (req_cs),
    .req_boot_addr_i          (req_boot),
    .timeout_limit_i          (timeout_limit),
    .abort_i                  (abort),
    .ext_master_core_o        (ext_master_core_o),
    .ext_safe_mode_o          (ext_safe_mode_o),
    .ext_safe_configuration_o (ext_safe_configuration_o),
    .ext_critical_section_o   (ext_critical_section_o),
    .ext_start_o              (ext_start_o),
    .boot_addr_o              (boot_addr_o),
    .end_sw_routine_i         (end_sw),
    .done_valid_o             (done_valid_o),
    .done_ready_i             (done_ready),
    .done_status_o            (done_status_o),
    .busy_o                   (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endfunction

  // e: RUN index from which end is held high (<=0 also high before RUN), DIS = never
  // a: RUN index of a one-cycle abort, DIS = none; sab: SETUP index of abort, 0 = none
  typedef struct {
    logic [2:0]  mc;
    logic        sm;
    logic [1:0]  sc;
    logic        cs;
    logic [31:0] boot;
    int          e, a, sab, l, bp;
  } job_t;

  typedef struct {
    int          status, runs, start_cyc, done_cyc;
    logic [38:0] cfg;
  } exp_t;

  exp_t exp_q[$];

  // Outcome from the rules: earliest event wins, ties resolved abort > end > timeout
  function automatic void model(input job_t j, output int st, output int runs, output int last);
    int te, ta, tt, t;
    if (j.sab > 0) begin
      st = 2; runs = 0; last = j.sab;
      return;
    end
    te = (j.e == DIS) ? BIG : ((j.e < 3) ? 3 : j.e);
    ta = (j.a == DIS) ? BIG : j.a;
    tt = BIG;
`ifdef SAFE_WRAPPER_EXT_SEQ_TIMEOUT_EN
    if (j.l != 0) tt = j.l;
`endif
    t = ta;
    if (te < t) t = te;
    if (tt < t) t = tt;
    if (ta == t)      st = 2;
    else if (te == t) st = 0;
    else              st = 1;
    runs = t;
    last = S + t;
  endfunction

  function automatic job_t mk(input int e, input int a, input int sab, input int l, input int bp);
    job_t j;
    j.mc = 3'($urandom); j.sm = 1'($urandom); j.sc = 2'($urandom); j.cs = 1'($urandom);
    j.boot = $urandom;
    j.e = e; j.a = a; j.sab = sab; j.l = l; j.bp = bp;
    return j;
  endfunction

  task automatic do_handshake(input job_t j, output int h);
    @(negedge clk);
    req_valid = 1'b1;
    req_mc = j.mc; req_sm = j.sm; req_sc = j.sc; req_cs = j.cs; req_boot = j.boot;
    timeout_limit = TW'(j.l);
    abort  = 1'($urandom);
    end_sw = (j.e != DIS) && (j.e < 0);
    done_ready = 1'b0;
    for (int k = 0; k < 50 && !req_ready_o; k++) @(negedge clk);
    if (!req_ready_o) check("req_ready_wait", req_ready_o, 1);
    h = cyc;
  endtask

  task automatic run_job(input job_t j);
    int h, st, runs, last, r;
    exp_t x;
    do_handshake(j, h);
    model(j, st, runs, last);
    x.status = st; x.runs = runs;
    x.start_cyc = (runs > 0) ? h + S + 1 : -1;
    x.done_cyc = h + last + 1;
    x.cfg = {j.mc, j.sm, j.sc, j.cs, j.boot};
    exp_q.push_back(x);
    for (int off = 1; off <= last; off++) begin
      @(negedge clk);
      req_valid = 1'b0;
      r = off - S;
      if (j.sab > 0) abort = (off == j.sab);
      else           abort = (j.a != DIS) && (r == j.a);
      end_sw = (j.e != DIS) && (r >= j.e);
    end
    for (int b = 0; b < j.bp; b++) begin
      @(negedge clk);
      req_valid = 1'b0;
      abort = 1'($urandom);
      end_sw = 1'($urandom);
    end
    @(negedge clk);
    req_valid = 1'b0; abort = 1'b0; end_sw = 1'b0; done_ready = 1'b1;
    for (int k = 0; k < 60 && !done_valid_o; k++) @(negedge clk);
    if (!done_valid_o) check("done_wait", done_valid_o, 1);
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  // Monitor: samples just after the falling edge, once inputs have settled
  int   run_cnt = 0, first_start = -1, first_done = -1;
  logic prev_hold = 1'b0;
  logic [1:0] prev_status = '0;
  always begin
    exp_t x;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      run_cnt = 0; first_start = -1; first_done = -1; prev_hold = 1'b0;
    end else begin
      if (ext_start_o) begin
        if (first_start < 0) first_start = cyc;
        run_cnt++;
      end
      if (prev_hold) begin
        check("done_hold_valid", done_valid_o, 1);
        check("done_hold_status", done_status_o, prev_status);
      end
      if (done_valid_o) begin
        if (first_done < 0) first_done = cyc;
        check("req_ready_in_done", req_ready_o, 0);
        check("start_in_done", ext_start_o, 0);
        if (done_ready) begin
          if (exp_q.size() == 0) begin
            check("done_without_job", exp_q.size(), 1);
          end else begin
            x = exp_q.pop_front();
            check("status", done_status_o, x.status);
            check("run_cycles", run_cnt, x.runs);
            check("start_cycle", first_start, x.start_cyc);
            check("done_cycle", first_done, x.done_cyc);
            check("cfg", {ext_master_core_o, ext_safe_mode_o, ext_safe_configuration_o,
                          ext_critical_section_o, boot_addr_o}, x.cfg);
          end
          run_cnt = 0; first_start = -1; first_done = -1;
        end
      end
      prev_hold = done_valid_o && !done_ready;
      prev_status = done_status_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, %0d jobs pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    job_t j, last_j;
    int   h, m, l, bp;
    logic bad;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_start", ext_start_o, 0);
    check("rst_done_valid", done_valid_o, 0);
    check("rst_status", done_status_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_cfg", {ext_master_core_o, ext_safe_mode_o, ext_safe_configuration_o,
                      ext_critical_section_o, boot_addr_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal job
    j = mk(3, DIS, 0, 0, 0); j.mc = 3'b101; j.boot = 32'h0000_0180;
    run_job(j);
    // End held high from before start: blanked for the first two RUN cycles
    j = mk(-5, DIS, 0, 0, 0); run_job(j);
`ifdef SAFE_WRAPPER_EXT_SEQ_TIMEOUT_EN
    j = mk(DIS, DIS, 0, 10, 0); run_job(j);
    j = mk(DIS, DIS, 0, 1, 0);  run_job(j);
`else
    j = mk(12, DIS, 0, 10, 0); run_job(j);
`endif
    // Coincident abort and end, then end and timeout expiry
    j = mk(5, 5, 0, 0, 0);  run_job(j);
    j = mk(5, DIS, 0, 5, 0); run_job(j);
    // Abort in first and last SETUP cycle
    j = mk(DIS, DIS, 1, 0, 0); run_job(j);
    j = mk(DIS, DIS, S, 0, 0); run_job(j);
    // Long backpressure
    j = mk(4, DIS, 0, 0, 20); run_job(j);

    for (int n = 0; n < 40; n++) begin
      m  = int'($urandom_range(0, 3));
      l  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
      bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      if (m == 2) j = mk(DIS, DIS, int'($urandom_range(1, S)), l, bp);
      else        j = mk(int'($urandom_range(0, 23)) - 3,
                         ($urandom_range(0, 1) == 0) ? DIS : int'($urandom_range(1, 15)),
                         0, l, bp);
      run_job(j);
    end
    last_j = j;

    // Configuration stays captured while idle
    repeat (2) @(negedge clk);
    check("cfg_retained", {ext_master_core_o, ext_safe_mode_o, ext_safe_configuration_o,
                           ext_critical_section_o, boot_addr_o},
          {last_j.mc, last_j.sm, last_j.sc, last_j.cs, last_j.boot});
    check("idle_busy", busy_o, 0);

    // Reset asserted during RUN discards the job
    j = mk(DIS, DIS, 0, 0, 0);
    do_handshake(j, h);
    for (int k = 0; k < S + 3; k++) begin
      @(negedge clk);
      req_valid = 1'b0; abort = 1'b0; end_sw = 1'b0;
    end
    check("start_before_reset", ext_start_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_start_async", ext_start_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_req_ready", req_ready_o, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bad = bad | done_valid_o | busy_o | ext_start_o | !req_ready_o;
    end
    check("idle_after_reset", bad, 0);

    // Recovery job after reset
    j = mk(6, DIS, 0, 0, 2); run_job(j);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/safe_wrapper_ext_seq.md
SAFE_WRAPPER_EXT_SEQ -- requirements
Module: safe_wrapper_ext_seq

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 4: cycles for which the configuration is held with start low before start rises; legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT_W, default 16: width of the run-time watchdog counter and limit.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 req_valid_i / req_ready_o  input / output  1 / 1  job request handshake; transfer on a cycle with both high.
REQ-006 req_master_core_i / req_safe_mode_i / req_safe_configuration_i / req_critical_section_i  input  3 / 1 / 2 / 1  job configuration fields.
REQ-007 req_boot_addr_i  input  32  job entry address.
REQ-008 timeout_limit_i  input  TIMEOUT_W  RUN-cycle limit; 0 disables the watchdog.
REQ-009 abort_i  input  1  cancel the current job.
REQ-010 ext_master_core_o / ext_safe_mode_o / ext_safe_configuration_o / ext_critical_section_o  output  3 / 1 / 2 / 1  registered configuration to the safe wrapper controller.
REQ-011 ext_start_o  output  1  registered start to the safe wrapper controller.
REQ-012 boot_addr_o  output  32  registered entry address.
REQ-013 end_sw_routine_i  input  1  end-of-routine flag from the safe wrapper controller.
REQ-014 done_valid_o / done_ready_i  output / input  1 / 1  completion handshake.
REQ-015 done_status_o  output  2  completion status: 00 OK, 01 TIMEOUT, 10 ABORT.
REQ-016 busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, SETUP, RUN and DONE.
REQ-018 IDLE: req_ready_o=1 (the only state in which it is high); on the handshake, capture all fields into the ext_*/boot_addr_o registers, load the setup counter with SETUP_CYCLES-1, and go to SETUP.
REQ-019 Captured ext_* and boot_addr_o values SHALL stay stable until the next accepted request; they SHALL NOT be cleared in DONE or IDLE.
REQ-020 SETUP: ext_start_o=0; decrement the counter each cycle; at 0 go to RUN; SETUP SHALL last exactly SETUP_CYCLES cycles.
REQ-021 RUN: ext_start_o=1; clear the blank and watchdog counters on entry.
REQ-022 end_sw_routine_i SHALL be ignored during the first 2 RUN cycles, because the target clears its end flag after start rises.
REQ-023 From the 3rd RUN cycle, end_sw_routine_i=1 SHALL move the FSM to DONE with status OK.
REQ-024 Watchdog (when compiled in): count RUN cycles; with timeout_limit_i≠0 and no qualifying end, go to DONE with status TIMEOUT after exactly timeout_limit_i RUN cycles.
REQ-025 Priority when events coincide in the same cycle: abort > qualifying end > timeout.
REQ-026 abort_i in SETUP or RUN SHALL go to DONE with status ABORT; abort_i in IDLE or DONE SHALL be ignored.
REQ-027 DONE: ext_start_o=0 from the first DONE cycle; done_valid_o=1 with done_status_o held stable until done_ready_i=1, then go to IDLE.
REQ-028 Latency: a handshake at edge N SHALL give ext_start_o=1 from cycle N+1+SETUP_CYCLES.
REQ-029 Latency: a qualifying end sampled at edge M SHALL give done_valid_o=1 and ext_start_o=0 at cycle M+1.
REQ-030 The watchdog counter SHALL saturate at all-ones and SHALL NOT wrap.

Reset
REQ-031 Reset SHALL put the FSM in IDLE and clear every counter.
REQ-032 Reset values: all ext_*, boot_addr_o, ext_start_o, done_valid_o, done_status_o and busy_o SHALL be 0; req_ready_o SHALL be 1.
REQ-033 Reset asserted mid-job SHALL drop ext_start_o asynchronously and discard the job with no completion reported.

Configuration
REQ-034 Macro SAFE_WRAPPER_EXT_SEQ_TIMEOUT_EN defined: the watchdog of REQ-024 and REQ-030 is present.
REQ-035 Macro SAFE_WRAPPER_EXT_SEQ_TIMEOUT_EN undefined: no watchdog counter; timeout_limit_i is ignored; status 01 is never produced; RUN waits indefinitely for end or abort.

Verification
REQ-036 Nominal job: SETUP_CYCLES=4, handshake at cycle 0 with master_core=3'b101, boot_addr=0x0000_0180; end_sw_routine_i=1 from cycle 7 -> ext_master_core_o=101 from cycle 1, ext_start_o high in cycles 5-7, done_valid_o=1 at cycle 8 with status 00.
REQ-037 End blanking: as REQ-036, but end_sw_routine_i held at 1 from cycle 0 -> end ignored in cycles 5-6, DONE entered at cycle 8.
REQ-038 Timeout (macro defined): timeout_limit_i=10, end never asserted -> ext_start_o high in cycles 5-14, done_valid_o=1 at cycle 15 with status 01.
REQ-039 Coincident events: abort_i and qualifying end in the same RUN cycle -> status 10; end and timeout expiry in the same cycle -> status 00.
REQ-040 Backpressure and mid-job reset: done_ready_i held at 0 for 20 cycles -> done_valid_o and status stay stable, req_ready_o=0 throughout; rst_ni pulsed low during RUN -> ext_start_o=0 immediately, IDLE after release, no done_valid_o.
